// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-port arbiter: state encoding,
// mux owner codes and the datapath word width.
package mips_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the shared port.
//
// Handshake: a requester raises i_req/d_req and holds it, with address and
// write data stable, until its one-cycle done pulse; memory completes the
// transaction by strobing mem_ready (with mem_rdata) while mem_req is high;
// err qualifies a done pulse as a timeout abort and is 0 otherwise.
interface mem_port_arbiter_if;
    import mips_pkg::*;

    logic              i_req;
    logic [DATA_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              owner;
    logic              i_done;
    logic              d_done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    arb_state_t        dbg_state;

    // Requesters and memory model side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, owner, i_done, d_done, rdata,
               err, dbg_state
    );

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, owner, i_done, d_done, rdata,
               err, dbg_state
    );

endinterface

// File: rtl/mux_32.sv
// Two-input 32-bit word mux: sel = 0 picks in1, sel = 1 picks in2.
module mux_32 (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        sel,
    output logic [31:0] dout
);

    assign dout = sel ? in2 : in1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (I) and
// data load/store (D). D has fixed priority; after STARVE_LIMIT contested
// D wins in a row, I is forced through. Each transaction aborts with err
// if mem_ready does not arrive within TIMEOUT busy cycles.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int TC_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [TC_W-1:0]   tc_q, tc_d;

    logic              mem_req_q, mem_req_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] zero_word;

    assign zero_word = '0;

    // Next-state logic: arbitration in IDLE, completion/timeout in busy states
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        sc_d     = sc_q;
        tc_d     = tc_q;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req && bus.d_req) begin
                    tc_d = '0;
                    if (sc_q == SC_W'(STARVE_LIMIT)) begin
                        state_d = BUSY_I;
                        owner_d = OWNER_I;
                        sc_d    = '0;
                    end else begin
                        state_d = BUSY_D;
                        owner_d = OWNER_D;
                        sc_d    = sc_q + 1'b1;
                    end
                end else if (bus.i_req) begin
                    state_d = BUSY_I;
                    owner_d = OWNER_I;
                    sc_d    = '0;
                    tc_d    = '0;
                end else if (bus.d_req) begin
                    state_d = BUSY_D;
                    owner_d = OWNER_D;
                    tc_d    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                tc_d = tc_q + 1'b1;
                // mem_ready takes precedence over a timeout in the same cycle
                if (bus.mem_ready) begin
                    state_d  = IDLE;
                    tc_d     = '0;
                    rdata_d  = bus.mem_rdata;
                    i_done_d = (state_q == BUSY_I);
                    d_done_d = (state_q == BUSY_D);
                end else if (tc_q == TC_W'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    tc_d     = '0;
                    rdata_d  = '0;
                    i_done_d = (state_q == BUSY_I);
                    d_done_d = (state_q == BUSY_D);
                    err_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_req_d = (state_d != IDLE);
    end

    // FSM state, owner select and the starvation/timeout counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWNER_I;
            sc_q    <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            sc_q    <= sc_d;
            tc_q    <= tc_d;
        end
    end

    // Registered outputs: memory request, done pulses, err and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            mem_req_q <= mem_req_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Address and write-data steering; write data is zero while I owns the port
    mux_32 u_addr_mux (
        .in1  (bus.i_addr),
        .in2  (bus.d_addr),
        .sel  (owner_q),
        .dout (bus.mem_addr)
    );

    mux_32 u_wdata_mux (
        .in1  (zero_word),
        .in2  (bus.d_wdata),
        .sel  (owner_q),
        .dout (bus.mem_wdata)
    );

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = (state_q == BUSY_D) & bus.d_we;
    assign bus.owner     = owner_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random
// request/latency mixes, checked against a transaction-level model of the
// grant, latency and completion rules.
module tb_mem_port_arbiter;
    import mips_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic clk;
    logic rst;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          starve    = 0;
    bit          i_pend    = 1'b0;
    bit          d_pend    = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_q[$];

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference grant decision; returns 1 when D should win
    function automatic bit model_grant(input bit ip, input bit dp);
        if (ip && dp) begin
            if (starve == STARVE_LIMIT) begin
                starve = 0;
                return 1'b0;
            end
            starve = starve + 1;
            return 1'b1;
        end
        if (ip) begin
            starve = 0;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic raise_i(input logic [31:0] a);
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        i_pend     = 1'b1;
    endtask

    task automatic raise_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        d_pend      = 1'b1;
    endtask

    task automatic drop_side(input bit side_d);
        if (side_d) begin
            bus.d_req = 1'b0;
            d_pend    = 1'b0;
        end else begin
            bus.i_req = 1'b0;
            i_pend    = 1'b0;
        end
    endtask

    // One transaction: wait for the grant, answer after `delay` busy cycles
    // (TIMEOUT or more means never), then check the completion
    task automatic serve(input int delay, input logic [31:0] rd_val, output bit won_d);
        int w;
        int n;
        bit exp_d;
        bit timed_out;
        exp_d = model_grant(i_pend, d_pend);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.mem_req && w < 10);
        check_eq("grant_latency", w, 1);
        check_eq("done_pulse_clear", {bus.i_done, bus.d_done, bus.err}, 0);
        won_d = bus.owner;
        check_eq("owner", bus.owner, exp_d);
        check_eq("mem_addr", bus.mem_addr, exp_d ? bus.d_addr : bus.i_addr);
        check_eq("mem_we", bus.mem_we, exp_d ? bus.d_we : 1'b0);
        if (exp_d) check_eq("mem_wdata", bus.mem_wdata, bus.d_wdata);
        n = 0;
        forever begin
            if (n == delay) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd_val;
            end
            @(negedge clk);
            n++;
            if (bus.i_done || bus.d_done || n >= 40) break;
        end
        timed_out = (delay >= TIMEOUT);
        exp_rdata = timed_out ? 32'd0 : rd_val;
        check_eq("done_latency", n, timed_out ? TIMEOUT : delay + 1);
        check_eq("i_done", bus.i_done, !exp_d);
        check_eq("d_done", bus.d_done, exp_d);
        check_eq("err", bus.err, timed_out);
        check_eq("rdata", bus.rdata, exp_rdata);
        check_eq("mem_req_after_done", bus.mem_req, 0);
        check_eq("state_after_done", 32'(bus.dbg_state), 32'(IDLE));
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
    endtask

    initial begin
        bit won;
        rst           = 1'b1;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_mem_req", bus.mem_req, 0);
        check_eq("rst_owner", bus.owner, 0);
        check_eq("rst_dones", {bus.i_done, bus.d_done, bus.err}, 0);
        check_eq("rst_rdata", bus.rdata, 0);
        check_eq("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;

        // Lone I read
        raise_i(32'h0040_0000);
        serve(3, 32'h2008_000A, won);
        drop_side(won);

        // Lone D write
        raise_d(1'b1, 32'h1001_0004, 32'd55);
        serve(1, $urandom, won);
        drop_side(won);

        // Contention with both requests held continuously
        exp_q = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        raise_i(32'h0040_0100);
        raise_d(1'b0, 32'h1001_0100, 32'h0);
        for (int k = 0; k < 10; k++) begin
            serve($urandom_range(0, 2), $urandom, won);
            check_eq("contention_grant", won, exp_q.pop_front());
        end
        drop_side(1'b0);
        drop_side(1'b1);

        // Timeout, then mem_ready on the final allowed cycle
        raise_d(1'b0, 32'h1001_0200, 32'h0);
        serve(99, $urandom, won);
        drop_side(won);
        raise_d(1'b0, 32'h1001_0204, 32'h0);
        serve(TIMEOUT - 1, 32'hCAFE_0001, won);
        drop_side(won);

        // Stray mem_ready while idle
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check_eq("stray_dones", {bus.i_done, bus.d_done, bus.err}, 0);
            check_eq("stray_rdata", bus.rdata, exp_rdata);
            check_eq("stray_mem_req", bus.mem_req, 0);
        end
        bus.mem_ready = 1'b0;

        // Asynchronous reset in the middle of a D transaction
        raise_d(1'b1, 32'h1001_0300, 32'h1234_5678);
        repeat (3) @(negedge clk);
        raise_i(32'h0040_0300);
        check_eq("pre_reset_state", 32'(bus.dbg_state), 32'(BUSY_D));
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_mem_req", bus.mem_req, 0);
        check_eq("async_rst_owner", bus.owner, 0);
        check_eq("async_rst_dones", {bus.i_done, bus.d_done, bus.err}, 0);
        check_eq("async_rst_rdata", bus.rdata, 0);
        drop_side(1'b1);
        starve    = 0;
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        serve(2, $urandom, won);
        drop_side(won);

        // Random request mixes and memory latencies
        for (int r = 0; r < 40; r++) begin
            int dly;
            if (!i_pend && $urandom_range(0, 1) == 1) raise_i($urandom);
            if (!d_pend && $urandom_range(0, 1) == 1)
                raise_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!i_pend && !d_pend) begin
                if ($urandom_range(0, 1) == 1) raise_i($urandom);
                else raise_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            dly = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
            serve(dly, $urandom, won);
            drop_side(won);
        end
        drop_side(1'b0);
        drop_side(1'b1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port between instruction fetch (I side) and data load/store (D side) in the MIPS datapath.
- Owns the select line of two mux_32 instances, one for the address and one for the write data, and sequences each memory transaction through a req/ready handshake.
- D side has fixed priority, with a starvation guard for I side and a per-transaction timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive contested arbitrations D may win before I is forced to win.
- TIMEOUT, 16: cycles in a busy state without mem_ready before the transaction aborts.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  I-side request; held until i_done
- i_addr  in  32  I-side address; stable while i_req is high
- d_req  in  1  D-side request; held until d_done
- d_we  in  1  D-side write enable
- d_addr  in  32  D-side address
- d_wdata  in  32  D-side write data
- mem_ready  in  1  memory completion strobe
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  muxed address
- mem_wdata  out  32  muxed write data
- owner  out  1  mux select: 0 = I (in1), 1 = D (in2)
- i_done  out  1  one-cycle completion pulse, I side
- d_done  out  1  one-cycle completion pulse, D side
- rdata  out  32  registered read data, valid with either done pulse
- err  out  1  qualifies a done pulse as a timeout abort

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Register state, owner, starvation counter (sc, clog2(STARVE_LIMIT+1) bits) and timeout counter (tc, clog2(TIMEOUT+1) bits).
- Reset (async, any time, including mid-transaction):
  - state = IDLE, owner = 0, sc = 0, tc = 0.
  - mem_req, i_done, d_done, err = 0; rdata = 0.
  - An abandoned memory transaction is not completed; mem_ready is ignored in IDLE.
- IDLE arbitration (evaluated every cycle):
  - Only i_req high: go to BUSY_I, owner <= 0.
  - Only d_req high: go to BUSY_D, owner <= 1.
  - Both high:
    - If sc == STARVE_LIMIT, I wins and sc <= 0.
    - Otherwise D wins and sc <= sc + 1.
  - Any I win clears sc.
  - No request: stay in IDLE, owner holds.
- Outputs:
  - mem_req = (state != IDLE), driven from a register.
  - mem_we = (state == BUSY_D) & d_we; it is 0 whenever I owns the port.
  - mem_addr and mem_wdata are combinational through the mux_32 instances selected by owner. mem_wdata passes d_wdata only when owner = 1; memory ignores it otherwise.
- Busy states:
  - tc increments each cycle; tc <= 0 on entry.
  - When mem_ready is high: rdata <= mem_rdata, the owner's done pulses for 1 cycle, err = 0, state returns to IDLE.
  - When tc == TIMEOUT-1 and mem_ready is low: rdata <= 0, the owner's done pulses with err = 1, state returns to IDLE.
  - mem_ready and timeout in the same cycle: mem_ready wins and err = 0.
- Latency:
  - Request sampled at edge 0 gives mem_req high after edge 0.
  - mem_ready sampled at edge k gives done/rdata valid for the cycle after edge k, with state IDLE in that same cycle.
  - A new arbitration happens at edge k+1, so there is at least one IDLE cycle between transactions.
- Request dropped mid-busy: ignored; the transaction completes and done still pulses. A requester must not drop req before done.
- Done pulses are mutually exclusive. err is 0 whenever no done is high.
- mem_ready in IDLE has no effect.

Decomposition:
- Shared package (mips_pkg):
  - State encoding constants: IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2.
  - OWNER_I = 1'b0, OWNER_D = 1'b1.
  - Data width constant 32.
- Sub-module: two instances of the existing mux_32, named u_addr_mux and u_wdata_mux.
- The FSM and counters stay in one always block plus an output register block; no further sub-modules.

Test Plan:
1. Lone I read: i_req = 1, i_addr = 0x0040_0000; mem_ready after 3 cycles with mem_rdata = 0x2008_000A. Expect owner = 0, mem_we = 0, mem_addr = 0x0040_0000, i_done for 1 cycle with rdata = 0x2008_000A, d_done = 0.
2. Lone D write: d_req = 1, d_we = 1, d_addr = 0x1001_0004, d_wdata = 55; mem_ready after 1 cycle. Expect owner = 1, mem_we = 1, mem_wdata = 55, d_done pulse, err = 0.
3. Contention and starvation: i_req and d_req held high continuously, mem_ready after 1 cycle each time. Expect grant sequence D,D,D,D,I,D,D,D,D,I with STARVE_LIMIT = 4, and sc cleared after each I win.
4. Timeout: d_req = 1 with mem_ready never asserted. Expect d_done with err = 1 and rdata = 0 exactly 16 cycles after mem_req rises, then IDLE. mem_ready landing on the final cycle instead gives err = 0.
5. Reset mid-transaction: assert rst asynchronously in BUSY_D between clock edges. Expect mem_req = 0, owner = 0, and no done pulse immediately; after release, a pending i_req is served first if D is idle.
6. Stray mem_ready = 1 in IDLE with no requests. Expect no done pulse and rdata unchanged.
